// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the core datapath (port 0) and the aux/IO unit (port 1).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round robin.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5,
  parameter int SH_W   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic [DATA_W-1:0] req_src_0,
  input  logic [DATA_W-1:0] req_src_1,
  input  logic [DATA_W-1:0] req_tgt_0,
  input  logic [DATA_W-1:0] req_tgt_1,
  input  logic [SH_W-1:0]   req_shamt_0,
  input  logic [SH_W-1:0]   req_shamt_1,
  input  logic [OP_W-1:0]   req_op_0,
  input  logic [OP_W-1:0]   req_op_1,
  output logic              resp_valid_0,
  output logic              resp_valid_1,
  input  logic              resp_ready_0,
  input  logic              resp_ready_1,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_zero,
  output logic [DATA_W-1:0] alu_src,
  output logic [DATA_W-1:0] alu_tgtImd,
  output logic [SH_W-1:0]   alu_shamt,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_zero,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_win;
  logic              w_accept;
  logic              w_resp_done;
  logic              w_grant_ready;
  logic              r_grant_id;
  logic              r_resp_valid_0;
  logic              r_resp_valid_1;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_zero;
  logic [DATA_W-1:0] r_alu_src;
  logic [DATA_W-1:0] r_alu_tgt;
  logic [SH_W-1:0]   r_alu_shamt;
  logic [OP_W-1:0]   r_alu_opcode;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_win = ~req_valid_0 & req_valid_1;
`else
  logic r_rr_ptr;

  // rr_ptr points away from the port that was just served
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= 1'b0;
    end else if (w_resp_done) begin
      r_rr_ptr <= ~r_grant_id;
    end
  end

  assign w_win = (req_valid_0 & req_valid_1) ? r_rr_ptr : req_valid_1;
`endif

  // Next-state decode and combinational request-ready
  always_comb begin
    w_state_nxt   = r_state;
    req_ready_0   = 1'b0;
    req_ready_1   = 1'b0;
    w_accept      = 1'b0;
    w_resp_done   = 1'b0;
    w_grant_ready = r_grant_id ? resp_ready_1 : resp_ready_0;
    case (r_state)
      S_IDLE: begin
        if (!reset && (req_valid_0 || req_valid_1)) begin
          w_accept    = 1'b1;
          req_ready_0 = ~w_win;
          req_ready_1 = w_win;
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP: begin
        if (w_grant_ready) begin
          w_resp_done = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand latch on accept, result capture in ISSUE, response handshake in RESP
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_grant_id     <= 1'b0;
      r_resp_valid_0 <= 1'b0;
      r_resp_valid_1 <= 1'b0;
      r_resp_data    <= '0;
      r_resp_zero    <= 1'b0;
      r_alu_src      <= '0;
      r_alu_tgt      <= '0;
      r_alu_shamt    <= '0;
      r_alu_opcode   <= '0;
    end else if (w_accept) begin
      r_alu_src    <= w_win ? req_src_1   : req_src_0;
      r_alu_tgt    <= w_win ? req_tgt_1   : req_tgt_0;
      r_alu_shamt  <= w_win ? req_shamt_1 : req_shamt_0;
      r_alu_opcode <= w_win ? req_op_1    : req_op_0;
      r_grant_id   <= w_win;
    end else if (r_state == S_ISSUE) begin
      r_resp_data    <= alu_data;
      r_resp_zero    <= alu_zero;
      r_alu_opcode   <= '0;
      r_resp_valid_0 <= ~r_grant_id;
      r_resp_valid_1 <= r_grant_id;
    end else if (w_resp_done) begin
      r_resp_valid_0 <= 1'b0;
      r_resp_valid_1 <= 1'b0;
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign grant_id     = r_grant_id;
  assign resp_valid_0 = r_resp_valid_0;
  assign resp_valid_1 = r_resp_valid_1;
  assign resp_data    = r_resp_data;
  assign resp_zero    = r_resp_zero;
  assign alu_src      = r_alu_src;
  assign alu_tgtImd   = r_alu_tgt;
  assign alu_shamt    = r_alu_shamt;
  assign alu_opcode   = r_alu_opcode;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: stub ALU, queue-driven requesters, transaction-level model and literal checks.
module tb_alu_share_arbiter;

  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_SUB = 5'b00101;
  localparam logic [4:0] OP_DIV = 5'b00111;
  localparam logic [4:0] OP_SLL = 5'b01000;
  localparam logic [4:0] OP_SLT = 5'b10011;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] s;
    logic [31:0] t;
    logic [4:0]  sh;
  } op_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        zero;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic port;
    int   cyc;
  } acc_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [31:0] req_src_0, req_src_1, req_tgt_0, req_tgt_1;
  logic [4:0]  req_shamt_0, req_shamt_1, req_op_0, req_op_1;
  logic        resp_valid_0, resp_valid_1, resp_ready_0, resp_ready_1;
  logic [31:0] resp_data;
  logic        resp_zero;
  logic [31:0] alu_src, alu_tgtImd, alu_data;
  logic [4:0]  alu_shamt, alu_opcode;
  logic        alu_zero, busy, grant_id;

  op_t  p0 = '0;
  op_t  p1 = '0;
  op_t  q0[$];
  op_t  q1[$];
  rsp_t rlog[$];
  acc_t alog[$];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic hs0_s = 1'b0;
  logic hs1_s = 1'b0;

  always #5 clock = ~clock;

  assign req_src_0 = p0.s;   assign req_src_1 = p1.s;
  assign req_tgt_0 = p0.t;   assign req_tgt_1 = p1.t;
  assign req_shamt_0 = p0.sh; assign req_shamt_1 = p1.sh;
  assign req_op_0 = p0.op;   assign req_op_1 = p1.op;

  alu_share_arbiter dut (
    .clock(clock), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_src_0(req_src_0), .req_src_1(req_src_1),
    .req_tgt_0(req_tgt_0), .req_tgt_1(req_tgt_1),
    .req_shamt_0(req_shamt_0), .req_shamt_1(req_shamt_1),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
    .resp_data(resp_data), .resp_zero(resp_zero),
    .alu_src(alu_src), .alu_tgtImd(alu_tgtImd),
    .alu_shamt(alu_shamt), .alu_opcode(alu_opcode),
    .alu_data(alu_data), .alu_zero(alu_zero),
    .busy(busy), .grant_id(grant_id)
  );

  // Stand-in for the shared ALU: {zero, data}
  function automatic logic [32:0] alu_fn(input logic [4:0] op, input logic [31:0] s,
                                         input logic [31:0] t, input logic [4:0] sh);
    logic [31:0] d;
    logic        z;
    d = 32'd0;
    z = 1'b0;
    case (op)
      OP_ADD: begin d = s + t; z = (d == 32'd0); end
      OP_SUB: begin d = s - t; z = (d == 32'd0); end
      OP_SLL: begin d = s << sh; z = (d == 32'd0); end
      OP_DIV: begin
        if (t != 32'd0) begin d = s / t; z = (d == 32'd0); end
      end
      OP_SLT: begin d = {31'd0, ($signed(s) < $signed(t))}; z = d[0]; end
      default: begin d = 32'd0; z = 1'b0; end
    endcase
    return {z, d};
  endfunction

  assign {alu_zero, alu_data} = alu_fn(alu_opcode, alu_src, alu_tgtImd, alu_shamt);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic model_win(input logic v0, input logic v1, input logic tie);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return v0 ? 1'b0 : 1'b1;
`else
    return (v0 && v1) ? tie : v1;
`endif
  endfunction

  // Transaction model: one op outstanding, age counts edges since acceptance
  logic        m_out = 1'b0;
  int          m_age = 0;
  logic        m_port = 1'b0;
  logic        m_tie = 1'b0;
  op_t         m_req = '0;
  logic [31:0] m_data = 32'd0;
  logic        m_zero = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_out <= 1'b0;
      m_age <= 0;
      m_tie <= 1'b0;
    end else if (!m_out) begin
      if (req_valid_0 || req_valid_1) begin
        m_out  <= 1'b1;
        m_age  <= 0;
        m_port <= model_win(req_valid_0, req_valid_1, m_tie);
        m_req  <= model_win(req_valid_0, req_valid_1, m_tie) ? p1 : p0;
        {m_zero, m_data} <= model_win(req_valid_0, req_valid_1, m_tie) ?
                            alu_fn(p1.op, p1.s, p1.t, p1.sh) : alu_fn(p0.op, p0.s, p0.t, p0.sh);
      end
    end else if (m_age == 0) begin
      m_age <= 1;
    end else if (m_port ? resp_ready_1 : resp_ready_0) begin
      m_out <= 1'b0;
      m_tie <= ~m_port;
    end
  end

  logic c_w;

  // Per-cycle compare against the model, plus handshake logging
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_ready0", req_ready_0, 0);
      chk("rst_ready1", req_ready_1, 0);
      chk("rst_rvalid0", resp_valid_0, 0);
      chk("rst_rvalid1", resp_valid_1, 0);
      chk("rst_opcode", alu_opcode, 0);
    end else begin
      c_w = model_win(req_valid_0, req_valid_1, m_tie);
      chk("busy", busy, m_out);
      chk("ready0", req_ready_0, !m_out && req_valid_0 && (c_w == 1'b0));
      chk("ready1", req_ready_1, !m_out && req_valid_1 && (c_w == 1'b1));
      chk("rvalid0", resp_valid_0, m_out && (m_age == 1) && (m_port == 1'b0));
      chk("rvalid1", resp_valid_1, m_out && (m_age == 1) && (m_port == 1'b1));
      chk("alu_opcode", alu_opcode, (m_out && m_age == 0) ? m_req.op : 5'd0);
      if (m_out) begin
        chk("grant_id", grant_id, m_port);
        if (m_age == 0) begin
          chk("alu_src", alu_src, m_req.s);
          chk("alu_tgt", alu_tgtImd, m_req.t);
          chk("alu_shamt", alu_shamt, m_req.sh);
        end else begin
          chk("resp_data", resp_data, m_data);
          chk("resp_zero", resp_zero, m_zero);
        end
      end
    end
    hs0_s = !reset && req_valid_0 && req_ready_0;
    hs1_s = !reset && req_valid_1 && req_ready_1;
    if (hs0_s) alog.push_back('{1'b0, cyc});
    if (hs1_s) alog.push_back('{1'b1, cyc});
    if (!reset && resp_valid_0 && resp_ready_0) rlog.push_back('{1'b0, resp_data, resp_zero, cyc});
    if (!reset && resp_valid_1 && resp_ready_1) rlog.push_back('{1'b1, resp_data, resp_zero, cyc});
  end

  // Requesters: present queue heads, drop an entry once it was accepted
  always @(posedge clock) begin
    #2;
    if (hs0_s && q0.size() > 0) void'(q0.pop_front());
    if (hs1_s && q1.size() > 0) void'(q1.pop_front());
    if (q0.size() > 0) begin p0 = q0[0]; req_valid_0 = 1'b1; end
    else req_valid_0 = 1'b0;
    if (q1.size() > 0) begin p1 = q1[0]; req_valid_1 = 1'b1; end
    else req_valid_1 = 1'b0;
  end

  task automatic push(input int port, input logic [4:0] op, input logic [31:0] s,
                      input logic [31:0] t, input logic [4:0] sh);
    op_t e;
    e.op = op; e.s = s; e.t = t; e.sh = sh;
    if (port == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clock); #1;
      k++;
    end while (!(q0.size() == 0 && q1.size() == 0 && !req_valid_0 && !req_valid_1 && !busy) && k < 300);
    chk("idle_timeout", (k < 300), 1);
  endtask

  task automatic do_reset();
    @(posedge clock); #2;
    reset = 1'b1;
    @(posedge clock); #2;
    reset = 1'b0;
    rlog.delete();
    alog.delete();
  endtask

  initial begin
    int k;
    int c_rdy;
    int c_val;
    reset = 1'b1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    chk("rst_resp_data", resp_data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_alu_src", alu_src, 0);
    reset = 1'b0;

    // Single add on port 0: ready same cycle, response two edges after acceptance
    push(0, OP_ADD, 32'd7, 32'd5, 5'd0);
    k = 0;
    do begin @(negedge clock); #1; k++; end while (!hs0_s && k < 20);
    chk("t1_ready_seen", hs0_s, 1);
    c_rdy = cyc;
    k = 0;
    do begin @(negedge clock); #1; k++; end while (!resp_valid_0 && k < 20);
    chk("t1_valid_seen", resp_valid_0, 1);
    c_val = cyc;
    chk("t1_latency", c_val - c_rdy, 2);
    chk("t1_data", resp_data, 12);
    chk("t1_zero", resp_zero, 0);
    wait_idle();

    // Simultaneous requests right after reset: port 0 first
    do_reset();
    push(0, OP_SUB, 32'd10, 32'd3, 5'd0);
    push(1, OP_SLT, 32'd2, 32'd9, 5'd0);
    wait_idle();
    chk("t2_count", rlog.size(), 2);
    if (rlog.size() == 2) begin
      chk("t2_first_port", rlog[0].port, 0);
      chk("t2_first_data", rlog[0].data, 7);
      chk("t2_first_zero", rlog[0].zero, 0);
      chk("t2_second_port", rlog[1].port, 1);
      chk("t2_second_data", rlog[1].data, 1);
      chk("t2_second_zero", rlog[1].zero, 1);
    end

    // Response backpressure on port 0 while port 1 waits
    do_reset();
    resp_ready_0 = 1'b0;
    push(0, OP_ADD, 32'd100, 32'd23, 5'd0);
    k = 0;
    do begin @(negedge clock); #1; k++; end while (!resp_valid_0 && k < 20);
    chk("t3_valid_seen", resp_valid_0, 1);
    push(1, OP_ADD, 32'd1, 32'd1, 5'd0);
    repeat (4) begin
      @(negedge clock); #1;
      chk("t3_hold_data", resp_data, 123);
      chk("t3_hold_valid", resp_valid_0, 1);
      chk("t3_ready1_low", req_ready_1, 0);
    end
    @(posedge clock); #2;
    resp_ready_0 = 1'b1;
    wait_idle();
    chk("t3_rcount", rlog.size(), 2);
    chk("t3_acount", alog.size(), 2);
    if (rlog.size() == 2 && alog.size() == 2) begin
      chk("t3_accept_next", alog[1].cyc - rlog[0].cyc, 1);
      chk("t3_p1_port", alog[1].port, 1);
      chk("t3_p1_data", rlog[1].data, 2);
    end

    // Continuous contention: grant order
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push(0, OP_ADD, i, 32'd1, 5'd0);
      push(1, OP_SUB, i + 20, i, 5'd0);
    end
    wait_idle();
    chk("t4_acount", alog.size(), 12);
    for (int i = 0; i < 6 && i < alog.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk($sformatf("t4_order_%0d", i), alog[i].port, 0);
`else
      chk($sformatf("t4_order_%0d", i), alog[i].port, i % 2);
`endif
    end

    // Reset during ISSUE discards the op
    do_reset();
    push(0, OP_ADD, 32'd1, 32'd2, 5'd0);
    k = 0;
    do begin @(negedge clock); #1; k++; end while (!hs0_s && k < 20);
    chk("t5_ready_seen", hs0_s, 1);
    @(posedge clock); #2;
    chk("t5_busy_issue", busy, 1);
    reset = 1'b1;
    #1;
    chk("t5_busy_rst", busy, 0);
    chk("t5_opcode_rst", alu_opcode, 0);
    @(posedge clock); #2;
    reset = 1'b0;
    rlog.delete();
    repeat (5) begin
      @(negedge clock); #1;
      chk("t5_no_rvalid", resp_valid_0 | resp_valid_1, 0);
    end
    chk("t5_no_resp", rlog.size(), 0);
    push(0, OP_ADD, 32'd40, 32'd2, 5'd0);
    wait_idle();
    chk("t5_next_count", rlog.size(), 1);
    if (rlog.size() == 1) chk("t5_next_data", rlog[0].data, 42);

    // Divide by zero, blank opcode, shift
    rlog.delete();
    push(1, OP_DIV, 32'd9, 32'd0, 5'd0);
    wait_idle();
    push(0, 5'b00000, 32'd5, 32'd5, 5'd0);
    wait_idle();
    push(0, OP_SLL, 32'd3, 32'd0, 5'd4);
    wait_idle();
    chk("t6_count", rlog.size(), 3);
    if (rlog.size() == 3) begin
      chk("t6_div_port", rlog[0].port, 1);
      chk("t6_div_data", rlog[0].data, 0);
      chk("t6_div_zero", rlog[0].zero, 0);
      chk("t6_blank_data", rlog[1].data, 0);
      chk("t6_blank_zero", rlog[1].zero, 0);
      chk("t6_sll_data", rlog[2].data, 48);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
